// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the inverse-mix FSM state encoding.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_mix_st_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1; the carry-out bit folds back as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Product with a constant below 16, built from the x, x^2 and x^3 multiples.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/aes_inv_mixcol_col.sv
// Combinational InvMixColumns of one 32-bit column; a0 is the top byte [31:24].
module aes_inv_mixcol_col
  import aes_pkg::*;
(
  input  aes_col_t col,
  output aes_col_t mixed
);

  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] a2;
  logic [7:0] a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Each output row uses the coefficient row {0e,0b,0d,09} rotated right by the row index.
  assign mixed[31:24] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
  assign mixed[23:16] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
  assign mixed[15:8]  = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
  assign mixed[7:0]   = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);

endmodule

// File: rtl/aes_inv_mixcol_engine.sv
// Decrypt round tail: AddRoundKey then InvMixColumns, COLS_PER_CYCLE columns per clock.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid holds with stable data until that edge; in_ready is high only in IDLE.
module aes_inv_mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  aes_state_t  in_state,
  input  aes_state_t  in_key,
  input  logic        skip_mix,
  output logic        out_valid,
  input  logic        out_ready,
  output aes_state_t  out_state,
  output logic        busy,
  output inv_mix_st_e dbg_state
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $fatal(1, "aes_inv_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  inv_mix_st_e state;
  logic [1:0]  cnt;
  logic [2:0]  cnt_sum;
  aes_state_t  work;
  aes_state_t  work_next;
  aes_col_t    grp_in  [COLS_PER_CYCLE];
  aes_col_t    grp_out [COLS_PER_CYCLE];

  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      grp_in[g] = work[127 - 32 * ((int'(cnt) + g) & 3) -: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    aes_inv_mixcol_col u_col (
      .col   (grp_in[g]),
      .mixed (grp_out[g])
    );
  end

  always_comb begin
    work_next = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_next[127 - 32 * ((int'(cnt) + g) & 3) -: 32] = grp_out[g];
    end
  end

  // A carry into bit 2 marks the last column group; the low bits wrap cnt back to 0.
  assign cnt_sum   = {1'b0, cnt} + STEP;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_state <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_state ^ in_key;
            cnt      <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (skip_mix) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_state <= in_state ^ in_key;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          work <= work_next;
          cnt  <= cnt_sum[1:0];
          if (cnt_sum[2]) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_state <= work_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_mixcol_engine.sv
// Bench for aes_inv_mixcol_engine: three instances (1, 2, 4 columns per cycle),
// a queue-based scoreboard on instance 0 and a matrix-level reference model.
module tb_aes_inv_mixcol_engine;
  import aes_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        busy      [3];
  aes_state_t  out_state [3];
  inv_mix_st_e dbg_state [3];
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         skip_mix;

  logic [127:0] exp_q[$];
  int n_pass;
  int n_total;

  // ---------------- clock / DUTs ----------------
  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CPC = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    aes_inv_mixcol_engine #(.COLS_PER_CYCLE(CPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_state  (in_state),
      .in_key    (in_key),
      .skip_mix  (skip_mix),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_state (out_state[k]),
      .busy      (busy[k]),
      .dbg_state (dbg_state[k])
    );
  end

  // ---------------- reference model ----------------
  // Generic shift-and-add multiply in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    logic [7:0] bb;
    r = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                         input logic skip);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] s;
    logic [127:0] r;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    s = st ^ key;
    if (skip) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 8 * (4 * c + j) -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ m_mul(coef[(j - i) & 3], a[j]);
        r[127 - 8 * (4 * c + i) -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid[0] && out_ready[0]) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got %h expected no output", out_state[0]);
        end else begin
          check("sb_result", out_state[0], exp_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_job(input int k, input logic [127:0] st, input logic [127:0] key,
                         input logic skip, input logic [127:0] exp, input string name);
    int   cpc;
    int   lat;
    int   guard;
    logic acc;
    logic rdy_seen;
    cpc = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    in_state    = st;
    in_key      = key;
    skip_mix    = skip;
    in_valid[k] = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid[k] = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL %s_accept: got no accept in %0d cycles expected accept", name, guard);
      return;
    end
    if (k == 0) exp_q.push_back(exp);
    in_state = rand128();
    in_key   = rand128();
    skip_mix = ~skip;
    lat      = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready[k]) rdy_seen = 1'b1;
    end while (!out_valid[k] && lat < 20);
    check({name, "_latency"}, 128'(lat), 128'(skip ? 1 : 4 / cpc + 1));
    check({name, "_in_ready_low"}, 128'(rdy_seen), 128'(0));
    check({name, "_busy"}, 128'(busy[k]), 128'(1));
    if (k != 0) check({name, "_out"}, out_state[k], exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] held;
    logic         sk;
    int           guard;
    bit           rand_done;

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    in_state = '0;
    in_key = '0;
    skip_mix = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready[0]), 128'(1));
    check("reset_out_valid", 128'(out_valid[0]), 128'(0));
    check("reset_busy", 128'(busy[0]), 128'(0));
    check("reset_out_state", out_state[0], 128'(0));

    fork
      monitor();
    join_none

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer columns: 8e4da1bc -> db135345, 9fdc589d -> f20a225c, two fixed points.
    st = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    for (int k = 0; k < 3; k++)
      run_job(k, st, '0, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
              $sformatf("kat_inst%0d", k));

    // Final round: state^key only, one cycle.
    for (int k = 0; k < 3; k++)
      run_job(k, '0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
              128'h000102030405060708090a0b0c0d0e0f, $sformatf("skip_inst%0d", k));

    // Random jobs on the wider instances.
    for (int n = 0; n < 4; n++) begin
      st = rand128();
      key = rand128();
      sk = 1'($urandom_range(0, 1));
      run_job(1 + (n & 1), st, key, sk, model(st, key, sk), $sformatf("rand_wide%0d", n));
    end

    // Stall in DONE with in_valid pulses that must be ignored.
    out_ready[0] = 1'b0;
    st = rand128();
    key = rand128();
    run_job(0, st, key, 1'b0, model(st, key, 1'b0), "stall_job");
    held = model(st, key, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'(i & 1);
      in_state = rand128();
      in_key = rand128();
      @(negedge clk);
      check("stall_out_valid", 128'(out_valid[0]), 128'(1));
      check("stall_out_state", out_state[0], held);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("post_handshake_in_ready", 128'(in_ready[0]), 128'(1));
    check("post_handshake_out_valid", 128'(out_valid[0]), 128'(0));
    check("post_handshake_queue", 128'(exp_q.size()), 128'(0));
    st = rand128();
    key = rand128();
    run_job(0, st, key, 1'b0, model(st, key, 1'b0), "after_stall");

    // Reset in the middle of a BUSY job.
    in_state = rand128();
    in_key = rand128();
    skip_mix = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("midjob_is_busy", 128'(busy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_out_valid", 128'(out_valid[0]), 128'(0));
    check("async_in_ready", 128'(in_ready[0]), 128'(1));
    check("async_out_state", out_state[0], 128'(0));
    check("async_busy", 128'(busy[0]), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    st = rand128();
    key = rand128();
    run_job(0, st, key, 1'b0, model(st, key, 1'b0), "after_reset");

    // Random jobs with random back-pressure on instance 0.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          logic [127:0] rs;
          logic [127:0] rk;
          logic         rsk;
          rs = rand128();
          rk = rand128();
          rsk = 1'($urandom_range(0, 1));
          run_job(0, rs, rk, rsk, model(rs, rk, rsk), $sformatf("rand%0d", n));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready[0] = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("drain_queue", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
